// File: rtl/store_narrow.sv
// Narrow store aligner: turns byte/half/word stores into lane-positioned write beats.
// Latency: beat in the cycle after acceptance, then a one-cycle done (or err) pulse.
// Backpressure: beats hold until mem_wr_ready; build with STORE_UNALIGNED_SPLIT_EN to split misaligned stores.
module store_narrow (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_size,
    output logic        mem_wr_valid,
    input  logic        mem_wr_ready,
    output logic [31:0] mem_wr_addr,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_wr_be,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, DONE, ERR} state_t;

    state_t      state, state_nxt;
    logic [29:0] word_q;
    logic [63:0] sh_q;
    logic [7:0]  bm_q;

    logic        accept;
    logic [1:0]  off;
    logic [3:0]  mask;
    logic [63:0] sh;
    logic [7:0]  bm;
    logic        bad;

    always_comb begin
        off  = req_addr[1:0];
        mask = 4'h0;
        bad  = 1'b1;
        case (req_size)
            2'b00: begin
                mask = 4'h1;
                bad  = 1'b0;
            end
            2'b01: begin
                mask = 4'h3;
`ifdef STORE_UNALIGNED_SPLIT_EN
                bad  = 1'b0;
`else
                bad  = off[0];
`endif
            end
            2'b10: begin
                mask = 4'hF;
`ifdef STORE_UNALIGNED_SPLIT_EN
                bad  = 1'b0;
`else
                bad  = (off != 2'b00);
`endif
            end
            default: begin
                mask = 4'h0;
                bad  = 1'b1;
            end
        endcase
        sh = {32'h0, req_data} << {off, 3'b000};
        bm = {4'h0, mask} << off;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Request fields are only observed outside IDLE, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            word_q <= req_addr[31:2];
            sh_q   <= sh;
            bm_q   <= bm;
        end
    end

    always_comb begin
        state_nxt    = state;
        req_ready    = (state == IDLE) & ~rst;
        accept       = 1'b0;
        mem_wr_valid = 1'b0;
        mem_wr_addr  = 32'h0;
        mem_wr_data  = 32'h0;
        mem_wr_be    = 4'h0;
        done         = 1'b0;
        err          = 1'b0;
        case (state)
            IDLE: begin
                accept = req_valid & req_ready;
                if (accept) state_nxt = bad ? ERR : BEAT0;
            end
            BEAT0: begin
                mem_wr_valid = 1'b1;
                mem_wr_addr  = {word_q, 2'b00};
                mem_wr_data  = sh_q[31:0];
                mem_wr_be    = bm_q[3:0];
                if (mem_wr_ready) state_nxt = (bm_q[7:4] != 4'h0) ? BEAT1 : DONE;
            end
            BEAT1: begin
                // Word address increment wraps naturally at the top of memory.
                mem_wr_valid = 1'b1;
                mem_wr_addr  = {word_q + 30'd1, 2'b00};
                mem_wr_data  = sh_q[63:32];
                mem_wr_be    = bm_q[7:4];
                if (mem_wr_ready) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            ERR: begin
                err       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
